multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multicycle successor to the single-cycle opcode decoder. Moore FSM sequences each
//  instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK on a shared memory and ALU.
//  Adds a memory-ready handshake, illegal-opcode detection and a state/cycle observation port.
//  Sits between the instruction register (opcode in) and the datapath muxes/enables (controls out).
// PARAMETERS
//  OP_W     6  opcode width; decode compares the OP_W-bit field against the 6-bit codes below,
//              zero-extended.
//  ALUOP_W  2  width of alu_op; codes 0=add, 1=sub, 2=funct-decode, rest unused.
//  MEM_HS   1  1: memory states wait for mem_ready; 0: mem_ready is ignored and treated as 1.
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        synchronous active-low reset
//  opcode       in   OP_W     opcode from the instruction register; sampled in DECODE only
//  mem_ready    in   1        memory completes the current access this cycle
//  pc_write     out  1        unconditional PC load
//  pc_write_br  out  1        PC load qualified by the datapath zero flag (BEQ)
//  pc_src       out  2        0=ALU result, 1=ALUOut reg, 2=jump target
//  i_or_d       out  1        memory address: 0=PC, 1=ALUOut
//  mem_read     out  1        memory read strobe
//  mem_write    out  1        memory write strobe
//  ir_write     out  1        load the instruction register
//  reg_write    out  1        register file write enable
//  reg_dst      out  1        1=rd, 0=rt
//  mem_to_reg   out  1        1=MDR, 0=ALUOut
//  alu_src_a    out  1        0=PC, 1=rs
//  alu_src_b    out  2        0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//  alu_op       out  ALUOP_W  ALU operation class
//  illegal_op   out  1        1-cycle pulse in DECODE when the opcode is unsupported
//  state_o      out  4        current state encoding, for debug
//  cyc_cnt      out  3        cycles spent in the current instruction; saturates at 7
// BEHAVIOUR
//  States (state_o): IDLE=0 FETCH=1 DECODE=2 MADDR=3 MREAD=4 MWB=5 MWRITE=6 REXEC=7 RWB=8
//    BEQ=9 IEXEC=10 IWB=11 JMP=12.
//  Reset: while rst_n=0 at a clk edge, state becomes IDLE and cyc_cnt becomes 0.
//    IDLE drives every control output 0; the next cycle always goes to FETCH.
//  Outputs not listed for a state are 0. Outputs are a function of state, plus mem_ready where noted.
//  FETCH: mem_read=1, i_or_d=0, alu_src_b=1, alu_op=add.
//    ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when 1.
//  DECODE: alu_src_b=3, alu_op=add (precomputes branch target). Next state by opcode:
//    000000->REXEC, 001000->IEXEC, 000100->BEQ, 100011/101011->MADDR, 000010->JMP.
//    Any other opcode: illegal_op=1 and next state is FETCH; no architectural write occurs.
//  MADDR: alu_src_a=1, alu_src_b=2, alu_op=add. Next: MREAD for LW, MWRITE for SW.
//    The opcode is latched in DECODE; opcode is not re-sampled here.
//  MREAD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MWB.
//  MWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
//  MWRITE: mem_write=1, i_or_d=1. Holds until mem_ready, then goes to FETCH.
//  REXEC: alu_src_a=1, alu_src_b=0, alu_op=funct. Next: RWB.
//  RWB: reg_write=1, reg_dst=1. Next: FETCH.
//  IEXEC: alu_src_a=1, alu_src_b=2, alu_op=add. Next: IWB.
//  IWB: reg_write=1, reg_dst=0. Next: FETCH.
//  BEQ: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_write_br=1, pc_src=1. Next: FETCH.
//  JMP: pc_write=1, pc_src=2. Next: FETCH.
//  Cycle counts with mem_ready tied 1: R=4, ADDI=4, BEQ=3, J=3, LW=5, SW=4.
//  cyc_cnt: cleared to 0 on entry to FETCH; otherwise +1 per cycle, saturating at 7.
//  mem_read and mem_write are never both 1. reg_write is never 1 in a state with mem_write=1.
//  Reset mid-instruction (any state, including a stalled MREAD/MWRITE):
//    the next cycle is IDLE and all strobes are low.
//  With MEM_HS=0, the FETCH, MREAD and MWRITE states each last exactly 1 cycle.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles, release -> IDLE with all outputs 0, then FETCH; mem_read=1 on
//    the next cycle.
//  2 LW 100011, mem_ready=1 -> states 1,2,3,4,5,1. In MWB: reg_write=1, mem_to_reg=1.
//    Total 5 cycles.
//  3 SW 101011 with mem_ready low 3 cycles in MWRITE -> mem_write=1 held for 4 cycles,
//    reg_write never 1, then FETCH.
//  4 Opcode 111111 -> illegal_op=1 for 1 cycle in DECODE, next state FETCH;
//    pc_write=reg_write=mem_write=0 in DECODE.
//  5 BEQ 000100 -> pc_write_br=1, pc_src=1, alu_op=1 for 1 cycle. J 000010 -> pc_write=1,
//    pc_src=2. Each totals 3 cycles.
//  6 rst_n=0 during a stalled MREAD -> next cycle IDLE with mem_read=0, then FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB on a shared
// memory and ALU, with a memory-ready handshake and illegal-opcode detection.
module multicycle_controller #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2,
  parameter bit MEM_HS  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_br,
  output logic [1:0]         pc_src,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op,
  output logic [3:0]         state_o,
  output logic [2:0]         cyc_cnt
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MADDR  = 4'd3,
    S_MREAD  = 4'd4,
    S_MWB    = 4'd5,
    S_MWRITE = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JMP    = 4'd12
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_cnt;
  logic                 r_is_sw;
  logic                 r_pc_jmp;
  logic                 r_pc_write_br;
  logic [1:0]           r_pc_src;
  logic                 r_i_or_d;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic                 r_reg_write;
  logic                 r_reg_dst;
  logic                 r_mem_to_reg;
  logic                 r_alu_src_a;
  logic [1:0]           r_alu_src_b;
  logic [ALUOP_W-1:0]   r_alu_op;

  logic        w_rdy;
  logic [31:0] w_opx;
  logic        w_op_r;
  logic        w_op_i;
  logic        w_op_beq;
  logic        w_op_lw;
  logic        w_op_sw;
  logic        w_op_j;
  logic        w_legal;
  logic        w_fetch_go;

  assign w_rdy    = MEM_HS ? mem_ready : 1'b1;
  assign w_opx    = 32'(opcode);
  assign w_op_r   = (w_opx == 32'd0);
  assign w_op_i   = (w_opx == 32'd8);
  assign w_op_beq = (w_opx == 32'd4);
  assign w_op_lw  = (w_opx == 32'd35);
  assign w_op_sw  = (w_opx == 32'd43);
  assign w_op_j   = (w_opx == 32'd2);
  assign w_legal  = w_op_r | w_op_i | w_op_beq |
                    w_op_lw | w_op_sw | w_op_j;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (w_rdy) w_next = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          w_op_r:            w_next = S_REXEC;
          w_op_i:            w_next = S_IEXEC;
          w_op_beq:          w_next = S_BEQ;
          w_op_lw, w_op_sw:  w_next = S_MADDR;
          w_op_j:            w_next = S_JMP;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MADDR:  w_next = r_is_sw ? S_MWRITE : S_MREAD;
      S_MREAD:  if (w_rdy) w_next = S_MWB;
      S_MWRITE: if (w_rdy) w_next = S_FETCH;
      S_REXEC:  w_next = S_RWB;
      S_IEXEC:  w_next = S_IWB;
      S_MWB, S_RWB, S_IWB,
      S_BEQ, S_JMP: w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 3'd0;
      r_is_sw       <= 1'b0;
      r_pc_jmp      <= 1'b0;
      r_pc_write_br <= 1'b0;
      r_pc_src      <= 2'd0;
      r_i_or_d      <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_reg_write   <= 1'b0;
      r_reg_dst     <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_alu_src_a   <= 1'b0;
      r_alu_src_b   <= 2'd0;
      r_alu_op      <= ALU_ADD;
    end else begin
      r_state <= w_next;
      if (w_next == S_FETCH && r_state != S_FETCH)
        r_cnt <= 3'd0;
      else if (r_cnt != 3'd7)
        r_cnt <= r_cnt + 3'd1;
      if (r_state == S_DECODE)
        r_is_sw <= w_op_sw;
      r_pc_jmp      <= 1'b0;
      r_pc_write_br <= 1'b0;
      r_pc_src      <= 2'd0;
      r_i_or_d      <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_reg_write   <= 1'b0;
      r_reg_dst     <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_alu_src_a   <= 1'b0;
      r_alu_src_b   <= 2'd0;
      r_alu_op      <= ALU_ADD;
      unique case (w_next)
        S_FETCH: begin
          r_mem_read  <= 1'b1;
          r_alu_src_b <= 2'd1;
        end
        S_DECODE: r_alu_src_b <= 2'd3;
        S_MADDR, S_IEXEC: begin
          r_alu_src_a <= 1'b1;
          r_alu_src_b <= 2'd2;
        end
        S_MREAD: begin
          r_mem_read <= 1'b1;
          r_i_or_d   <= 1'b1;
        end
        S_MWB: begin
          r_reg_write  <= 1'b1;
          r_mem_to_reg <= 1'b1;
        end
        S_MWRITE: begin
          r_mem_write <= 1'b1;
          r_i_or_d    <= 1'b1;
        end
        S_REXEC: begin
          r_alu_src_a <= 1'b1;
          r_alu_op    <= ALU_FN;
        end
        S_RWB: begin
          r_reg_write <= 1'b1;
          r_reg_dst   <= 1'b1;
        end
        S_IWB: r_reg_write <= 1'b1;
        S_BEQ: begin
          r_alu_src_a   <= 1'b1;
          r_alu_op      <= ALU_SUB;
          r_pc_write_br <= 1'b1;
          r_pc_src      <= 2'd1;
        end
        S_JMP: begin
          r_pc_jmp <= 1'b1;
          r_pc_src <= 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign w_fetch_go  = (r_state == S_FETCH) & w_rdy;
  assign pc_write    = r_pc_jmp | w_fetch_go;
  assign ir_write    = w_fetch_go;
  assign illegal_op  = (r_state == S_DECODE) & ~w_legal;
  assign pc_write_br = r_pc_write_br;
  assign pc_src      = r_pc_src;
  assign i_or_d      = r_i_or_d;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign reg_write   = r_reg_write;
  assign reg_dst     = r_reg_dst;
  assign mem_to_reg  = r_mem_to_reg;
  assign alu_src_a   = r_alu_src_a;
  assign alu_src_b   = r_alu_src_b;
  assign alu_op      = r_alu_op;
  assign state_o     = r_state;
  assign cyc_cnt     = r_cnt;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus randomized
// opcode/mem_ready streams against an instruction-level reference model.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_br, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic       illegal_op;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state_o;
  logic [2:0] cyc_cnt;

  logic       mr1;
  logic [5:0] op1;
  logic       pcw1, pcwb1, iod1, mrd1, mwr1, irw1, rw1, rd1, m2r1, asa1;
  logic       ill1;
  logic [1:0] pcs1, asb1, aop1;
  logic [3:0] st1;
  logic [2:0] cnt1;

  int n_chk = 0;
  int n_fail = 0;

  multicycle_controller u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_br(pc_write_br), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op),
    .state_o(state_o), .cyc_cnt(cyc_cnt)
  );

  multicycle_controller #(.MEM_HS(1'b0)) u_nohs (
    .clk(clk), .rst_n(rst_n), .opcode(op1), .mem_ready(mr1),
    .pc_write(pcw1), .pc_write_br(pcwb1), .pc_src(pcs1),
    .i_or_d(iod1), .mem_read(mrd1), .mem_write(mwr1),
    .ir_write(irw1), .reg_write(rw1), .reg_dst(rd1),
    .mem_to_reg(m2r1), .alu_src_a(asa1),
    .alu_src_b(asb1), .alu_op(aop1), .illegal_op(ill1),
    .state_o(st1), .cyc_cnt(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [16:0] outs();
    return {pc_write, pc_write_br, pc_src, i_or_d, mem_read, mem_write,
            ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
            alu_src_b, alu_op, illegal_op};
  endfunction

  // Control word expected in state st, from the per-state output table.
  function automatic logic [16:0] exp_out(int st, bit rdy, bit ill);
    logic pcw, pcwb, iod, mr, mw, irw, rw, rd, m2r, asa;
    logic [1:0] pcs, asb, aop;
    {pcw, pcwb, iod, mr, mw, irw, rw, rd, m2r, asa} = '0;
    pcs = 2'd0; asb = 2'd0; aop = 2'd0;
    case (st)
      1:  begin mr = 1; asb = 2'd1; pcw = rdy; irw = rdy; end
      2:  asb = 2'd3;
      3:  begin asa = 1; asb = 2'd2; end
      4:  begin mr = 1; iod = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mw = 1; iod = 1; end
      7:  begin asa = 1; aop = 2'd2; end
      8:  begin rw = 1; rd = 1; end
      9:  begin asa = 1; aop = 2'd1; pcwb = 1; pcs = 2'd1; end
      10: begin asa = 1; asb = 2'd2; end
      11: rw = 1;
      12: begin pcw = 1; pcs = 2'd2; end
      default: ;
    endcase
    return {pcw, pcwb, pcs, iod, mr, mw, irw, rw, rd, m2r, asa,
            asb, aop, ill};
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h04, 6'h23, 6'h2B, 6'h02};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00;
    op1 = 6'h23; mr1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (state_o !== 4'd0 || outs() !== 17'd0 || cyc_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_hold state=%0d outs=%h cnt=%0d want 0/0/0",
               state_o, outs(), cyc_cnt);
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (state_o !== 4'd0 || outs() !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_idle state=%0d outs=%h want 0/0",
               state_o, outs());
    end
    tick();
    #1;
    n_chk++;
    if (state_o !== 4'd1 || mem_read !== 1'b1 || cyc_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_fetch state=%0d mem_read=%0d cnt=%0d want 1/1/0",
               state_o, mem_read, cyc_cnt);
    end
  endtask

  task automatic test_lw();
    int seq[5] = '{1, 2, 3, 4, 5};
    opcode = 6'h23; mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_chk++;
      if (state_o !== 4'(seq[k]) || outs() !== exp_out(seq[k], 1'b1, 1'b0)
          || cyc_cnt !== 3'(k)) begin
        n_fail++;
        $display("FAIL lw k=%0d state=%0d outs=%h cnt=%0d want %0d/%h/%0d",
                 k, state_o, outs(), cyc_cnt, seq[k],
                 exp_out(seq[k], 1'b1, 1'b0), k);
      end
      tick();
      // Opcode is only meaningful in DECODE; a changed value must not matter.
      if (k == 1) opcode = 6'h2B;
    end
    #1;
    n_chk++;
    if (state_o !== 4'd1 || cyc_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL lw_end state=%0d cnt=%0d want 1/0", state_o, cyc_cnt);
    end
  endtask

  task automatic test_sw_stall();
    int seq[7] = '{1, 2, 3, 6, 6, 6, 6};
    bit rdy[7] = '{1, 1, 1, 0, 0, 0, 1};
    int mw = 0;
    bit rw_seen = 0;
    opcode = 6'h2B;
    for (int k = 0; k < 7; k++) begin
      mem_ready = rdy[k];
      #1;
      n_chk++;
      if (state_o !== 4'(seq[k]) || outs() !== exp_out(seq[k], rdy[k], 1'b0)
          || cyc_cnt !== 3'(k)) begin
        n_fail++;
        $display("FAIL sw k=%0d state=%0d outs=%h cnt=%0d want %0d/%h/%0d",
                 k, state_o, outs(), cyc_cnt, seq[k],
                 exp_out(seq[k], rdy[k], 1'b0), k);
      end
      if (mem_write === 1'b1) mw++;
      if (reg_write !== 1'b0) rw_seen = 1;
      tick();
    end
    #1;
    n_chk++;
    if (mw != 4 || rw_seen || state_o !== 4'd1) begin
      n_fail++;
      $display("FAIL sw_end mem_write_cycles=%0d reg_write_seen=%0d state=%0d want 4/0/1",
               mw, rw_seen, state_o);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] codes[2] = '{6'h3F, 6'h01};
    mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      opcode = codes[c];
      for (int k = 0; k < 2; k++) begin
        #1;
        n_chk++;
        if (state_o !== 4'(k + 1) || outs() !== exp_out(k + 1, 1'b1, k == 1)
            || illegal_op !== 1'(k)) begin
          n_fail++;
          $display("FAIL illegal op=%h k=%0d state=%0d outs=%h want %0d/%h",
                   codes[c], k, state_o, outs(), k + 1,
                   exp_out(k + 1, 1'b1, k == 1));
        end
        tick();
      end
      #1;
      n_chk++;
      if (state_o !== 4'd1 || illegal_op !== 1'b0 || cyc_cnt !== 3'd0) begin
        n_fail++;
        $display("FAIL illegal_end state=%0d ill=%0d cnt=%0d want 1/0/0",
                 state_o, illegal_op, cyc_cnt);
      end
    end
  endtask

  task automatic test_beq_j();
    logic [5:0] codes[2] = '{6'h04, 6'h02};
    int last[2] = '{9, 12};
    int seq[3];
    mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      opcode = codes[c];
      seq = '{1, 2, last[c]};
      for (int k = 0; k < 3; k++) begin
        #1;
        n_chk++;
        if (state_o !== 4'(seq[k]) || outs() !== exp_out(seq[k], 1'b1, 1'b0)
            || cyc_cnt !== 3'(k)) begin
          n_fail++;
          $display("FAIL br op=%h k=%0d state=%0d outs=%h cnt=%0d want %0d/%h/%0d",
                   codes[c], k, state_o, outs(), cyc_cnt, seq[k],
                   exp_out(seq[k], 1'b1, 1'b0), k);
        end
        tick();
      end
      #1;
      n_chk++;
      if (state_o !== 4'd1) begin
        n_fail++;
        $display("FAIL br_end op=%h state=%0d want 1", codes[c], state_o);
      end
    end
  endtask

  task automatic test_reset_stall();
    opcode = 6'h23; mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_chk++;
      if (state_o !== 4'd4 || mem_read !== 1'b1
          || cyc_cnt !== 3'((3 + i > 7) ? 7 : 3 + i)) begin
        n_fail++;
        $display("FAIL mread_stall i=%0d state=%0d mem_read=%0d cnt=%0d want 4/1/%0d",
                 i, state_o, mem_read, cyc_cnt, (3 + i > 7) ? 7 : 3 + i);
      end
      if (i < 5) tick();
    end
    rst_n = 1'b0;
    tick();
    #1;
    n_chk++;
    if (state_o !== 4'd0 || mem_read !== 1'b0 || outs() !== 17'd0
        || cyc_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_stall state=%0d outs=%h cnt=%0d want 0/0/0",
               state_o, outs(), cyc_cnt);
    end
    rst_n = 1'b1;
    tick();
    #1;
    n_chk++;
    if (state_o !== 4'd1 || cyc_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_stall_fetch state=%0d cnt=%0d want 1/0",
               state_o, cyc_cnt);
    end
  endtask

  task automatic test_random();
    int st = 1;
    int cnt = 0;
    int nxt;
    int pq[$];
    logic [5:0] op;
    bit rdy, ill;
    logic [5:0] legal[6] = '{6'h00, 6'h08, 6'h04, 6'h23, 6'h2B, 6'h02};
    for (int c = 0; c < 300; c++) begin
      op = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 5)]
                                        : 6'($urandom_range(0, 63));
      rdy = 1'($urandom_range(0, 1));
      opcode = op; mem_ready = rdy;
      ill = (st == 2) && !is_legal(op);
      #1;
      n_chk++;
      if (state_o !== 4'(st)) begin
        n_fail++;
        $display("FAIL rnd_state c=%0d got=%0d want=%0d", c, state_o, st);
      end
      n_chk++;
      if (outs() !== exp_out(st, rdy, ill)) begin
        n_fail++;
        $display("FAIL rnd_outs c=%0d st=%0d got=%h want=%h",
                 c, st, outs(), exp_out(st, rdy, ill));
      end
      n_chk++;
      if (cyc_cnt !== 3'(cnt)) begin
        n_fail++;
        $display("FAIL rnd_cnt c=%0d got=%0d want=%0d", c, cyc_cnt, cnt);
      end
      n_chk++;
      if (mem_read === 1'b1 && mem_write === 1'b1) begin
        n_fail++;
        $display("FAIL rnd_rw_excl c=%0d mem_read=1 mem_write=1 want not both", c);
      end
      if ((st == 1 || st == 4 || st == 6) && !rdy) begin
        nxt = st;
      end else if (st == 1) begin
        nxt = 2;
      end else begin
        if (st == 2) begin
          pq.delete();
          case (op)
            6'h00: begin pq.push_back(7); pq.push_back(8); end
            6'h08: begin pq.push_back(10); pq.push_back(11); end
            6'h04: pq.push_back(9);
            6'h23: begin pq.push_back(3); pq.push_back(4); pq.push_back(5); end
            6'h2B: begin pq.push_back(3); pq.push_back(6); end
            6'h02: pq.push_back(12);
            default: ;
          endcase
        end
        nxt = (pq.size() > 0) ? pq.pop_front() : 1;
      end
      cnt = (nxt == 1 && st != 1) ? 0 : ((cnt < 7) ? cnt + 1 : 7);
      st = nxt;
      tick();
    end
  endtask

  task automatic test_no_hs();
    int prev = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      n_chk++;
      if (k == 0 ? !(st1 inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5})
                 : (st1 !== 4'((prev == 5) ? 1 : prev + 1))) begin
        n_fail++;
        $display("FAIL nohs_seq k=%0d prev=%0d got=%0d", k, prev, st1);
      end
      if (st1 === 4'd1) begin
        n_chk++;
        if (irw1 !== 1'b1 || pcw1 !== 1'b1 || mrd1 !== 1'b1) begin
          n_fail++;
          $display("FAIL nohs_fetch ir_write=%0d pc_write=%0d mem_read=%0d want 1/1/1",
                   irw1, pcw1, mrd1);
        end
      end
      prev = int'(st1);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'h00;
    mem_ready = 1'b0;
    op1 = 6'h23;
    mr1 = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_illegal();
    test_beq_j();
    test_reset_stall();
    test_random();
    test_no_hs();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
